ace_ack_gen: RTL and testbench

ACE acknowledge generator and outstanding-transaction limiter, placed directly upstream of the ACE cut on the master-facing side of a coherent requester. It passes all five channels through, drives the ACE read and write acknowledges (RACK/WACK) that the cut registers, and stalls new AR/AW requests once `MaxTrans` transactions per direction are outstanding. Upstream logic never drives acknowledges itself.

---
 rtl/ace_ack_gen_pkg.sv | 57 +++++
 rtl/ace_ack_cnt.sv | 50 +++++
 rtl/ace_ack_gen.sv | 73 +++++++
 tb/tb_ace_ack_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_ack_gen_pkg.sv
// ACE channel and request/response types shared by the acknowledge generator.
package ace_ack_gen_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ace_ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ace_aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } ace_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } ace_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  resp;
    logic        last;
  } ace_r_chan_t;

  typedef struct packed {
    ace_aw_chan_t aw;
    logic         aw_valid;
    ace_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    ace_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
    logic         wack;
    logic         rack;
  } ace_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    ace_b_chan_t  b;
    logic         b_valid;
    ace_r_chan_t  r;
    logic         r_valid;
  } ace_resp_t;

endpackage

// File: rtl/ace_ack_cnt.sv
// Per-direction outstanding counter with registered one-cycle acknowledge.
// The count includes the acknowledge cycle; the slot frees on the edge ending it.
module ace_ack_cnt #(
  parameter int unsigned MaxTrans = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  input  logic complete_i,
  output logic full_o,
  output logic ack_o,
  output logic empty_o,
  output logic err_o
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_ack;
  logic            r_err;
  logic            w_zero;

  assign w_zero = (r_cnt == '0);

  // Count issues and acknowledges; a completion with nothing outstanding is sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= complete_i;
      if (complete_i && w_zero) begin
        r_err <= 1'b1;
      end
      if (issue_i && !r_ack) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (!issue_i && r_ack && !w_zero) begin
        // Saturates at zero after an erroneous completion.
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end

  assign full_o  = (r_cnt == CntW'(MaxTrans));
  assign ack_o   = r_ack;
  assign empty_o = w_zero & ~r_ack;
  assign err_o   = r_err;

endmodule

// File: rtl/ace_ack_gen.sv
// ACE RACK/WACK generator and outstanding-transaction limiter.
// All channels pass through; AR/AW are gated once MaxTrans are outstanding.
module ace_ack_gen
  import ace_ack_gen_pkg::*;
#(
  parameter int unsigned MaxTrans   = 8,
  parameter type         axi_req_t  = ace_req_t,
  parameter type         axi_resp_t = ace_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i,
  output logic      idle_o,
  output logic      err_o
);

  logic w_rd_full, w_wr_full;
  logic w_ar_hs, w_aw_hs;
  logic w_r_done, w_b_done;
  logic w_rack, w_wack;
  logic w_rd_empty, w_wr_empty;
  logic w_rd_err, w_wr_err;

  assign w_ar_hs  = slv_req_i.ar_valid & mst_resp_i.ar_ready & ~w_rd_full;
  assign w_aw_hs  = slv_req_i.aw_valid & mst_resp_i.aw_ready & ~w_wr_full;
  assign w_r_done = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign w_b_done = mst_resp_i.b_valid & slv_req_i.b_ready;

  // Pass everything through, then override gated handshakes and the acknowledges.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~w_rd_full;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~w_wr_full;
    mst_req_o.rack     = w_rack;
    mst_req_o.wack     = w_wack;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~w_rd_full;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~w_wr_full;
  end

  ace_ack_cnt #(
    .MaxTrans (MaxTrans)
  ) u_rd_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_i    (w_ar_hs),
    .complete_i (w_r_done),
    .full_o     (w_rd_full),
    .ack_o      (w_rack),
    .empty_o    (w_rd_empty),
    .err_o      (w_rd_err)
  );

  ace_ack_cnt #(
    .MaxTrans (MaxTrans)
  ) u_wr_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_i    (w_aw_hs),
    .complete_i (w_b_done),
    .full_o     (w_wr_full),
    .ack_o      (w_wack),
    .empty_o    (w_wr_empty),
    .err_o      (w_wr_err)
  );

  assign idle_o = w_rd_empty & w_wr_empty;
  assign err_o  = w_rd_err | w_wr_err;

endmodule

// File: tb/tb_ace_ack_gen.sv
// Randomized and directed bench for ace_ack_gen with a transaction-level reference model.
module tb_ace_ack_gen;
  import ace_ack_gen_pkg::*;

  localparam int MT = 2;

  logic      clk;
  logic      rst;
  ace_req_t  slv_req;
  ace_resp_t slv_resp;
  ace_req_t  mst_req;
  ace_resp_t mst_resp;
  logic      idle;
  logic      err;

  int n_total;
  int n_bad;

  // Reference model: outstanding transactions per direction and pending acknowledges.
  int rd_out, wr_out;
  bit rack_m, wack_m, err_m;

  ace_ack_gen #(
    .MaxTrans (MT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .idle_o     (idle),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    slv_req          = '0;
    mst_resp         = '0;
    slv_req.b_ready  = 1'b1;
    slv_req.r_ready  = 1'b1;
    // Upstream ack fields are garbage and must be ignored.
    slv_req.rack     = 1'b1;
    slv_req.wack     = 1'b1;
    mst_resp.ar_ready = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
  endtask

  task automatic model_reset();
    rd_out = 0;
    wr_out = 0;
    rack_m = 1'b0;
    wack_m = 1'b0;
    err_m  = 1'b0;
  endtask

  // Inputs are driven in the low phase; compare, then advance the model across one edge.
  task automatic step();
    bit ar_hs, aw_hs, r_done, b_done, err_n;
    int rd_n, wr_n;
    #1;
    check("ar_valid", 64'(mst_req.ar_valid), 64'(slv_req.ar_valid && rd_out < MT));
    check("ar_ready", 64'(slv_resp.ar_ready), 64'(mst_resp.ar_ready && rd_out < MT));
    check("aw_valid", 64'(mst_req.aw_valid), 64'(slv_req.aw_valid && wr_out < MT));
    check("aw_ready", 64'(slv_resp.aw_ready), 64'(mst_resp.aw_ready && wr_out < MT));
    check("rack", 64'(mst_req.rack), 64'(rack_m));
    check("wack", 64'(mst_req.wack), 64'(wack_m));
    check("idle", 64'(idle), 64'(rd_out == 0 && wr_out == 0 && !rack_m && !wack_m));
    check("err", 64'(err), 64'(err_m));
    check("ar_pass", 64'(mst_req.ar), 64'(slv_req.ar));
    check("aw_pass", 64'(mst_req.aw), 64'(slv_req.aw));
    check("w_pass", 64'(mst_req.w), 64'(slv_req.w));
    check("r_pass", 64'(slv_resp.r), 64'(mst_resp.r));
    check("b_pass", 64'(slv_resp.b), 64'(mst_resp.b));
    check("hs_pass",
          64'({mst_req.w_valid, mst_req.b_ready, mst_req.r_ready,
               slv_resp.w_ready, slv_resp.b_valid, slv_resp.r_valid}),
          64'({slv_req.w_valid, slv_req.b_ready, slv_req.r_ready,
               mst_resp.w_ready, mst_resp.b_valid, mst_resp.r_valid}));
    ar_hs  = slv_req.ar_valid && mst_resp.ar_ready && rd_out < MT;
    aw_hs  = slv_req.aw_valid && mst_resp.aw_ready && wr_out < MT;
    r_done = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
    b_done = mst_resp.b_valid && slv_req.b_ready;
    err_n  = err_m || (r_done && rd_out == 0) || (b_done && wr_out == 0);
    rd_n   = rd_out + (ar_hs ? 1 : 0) - (rack_m ? 1 : 0);
    wr_n   = wr_out + (aw_hs ? 1 : 0) - (wack_m ? 1 : 0);
    if (rd_n < 0) rd_n = 0;
    if (wr_n < 0) wr_n = 0;
    @(posedge clk);
    rd_out = rd_n;
    wr_out = wr_n;
    rack_m = r_done;
    wack_m = b_done;
    err_m  = err_n;
    @(negedge clk);
  endtask

  // Complete everything outstanding so directed tests start from idle.
  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (rd_out == 0 && wr_out == 0 && !rack_m && !wack_m) break;
      set_idle();
      if (rd_out > (rack_m ? 1 : 0)) begin
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
      end
      if (wr_out > (wack_m ? 1 : 0)) mst_resp.b_valid = 1'b1;
      step();
    end
    set_idle();
    #1;
    check("drain_idle", 64'(idle), 64'(1));
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    n_total = 0;
    n_bad   = 0;
    set_idle();
    model_reset();

    // Reset state.
    #12;
    check("rst_rack", 64'(mst_req.rack), 64'(0));
    check("rst_wack", 64'(mst_req.wack), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_err", 64'(err), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    step();

    // Three ARs against a limit of two; third is released the cycle after RACK.
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id = 4'd0;
    step();
    slv_req.ar.id = 4'd1;
    step();
    slv_req.ar.id = 4'd2;
    #1;
    check("tp1_stall", 64'(mst_req.ar_valid), 64'(0));
    step();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    mst_resp.r.id    = 4'd0;
    step();
    mst_resp.r_valid = 1'b0;
    #1;
    check("tp1_rack", 64'(mst_req.rack), 64'(1));
    check("tp1_blocked_in_rack", 64'(mst_req.ar_valid), 64'(0));
    step();
    #1;
    check("tp1_rack_once", 64'(mst_req.rack), 64'(0));
    check("tp1_accept", 64'(mst_req.ar_valid), 64'(1));
    step();
    slv_req.ar_valid = 1'b0;
    drain();

    // Four-beat burst: RACK only after the last beat.
    slv_req.ar_valid = 1'b1;
    step();
    slv_req.ar_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = (b == 3);
      mst_resp.r.data  = $urandom;
      #1;
      check("tp2_no_rack", 64'(mst_req.rack), 64'(0));
      step();
    end
    mst_resp.r_valid = 1'b0;
    #1;
    check("tp2_rack", 64'(mst_req.rack), 64'(1));
    step();
    #1;
    check("tp2_rack_done", 64'(mst_req.rack), 64'(0));
    step();

    // AW and B in the same cycle, then a lone B; WACK holds the slot for its cycle.
    slv_req.aw_valid = 1'b1;
    step();
    mst_resp.b_valid = 1'b1;
    step();
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    #1;
    check("tp3_wack", 64'(mst_req.wack), 64'(1));
    step();
    mst_resp.b_valid = 1'b1;
    step();
    mst_resp.b_valid = 1'b0;
    #1;
    check("tp3_wack2", 64'(mst_req.wack), 64'(1));
    check("tp3_busy", 64'(idle), 64'(0));
    step();
    #1;
    check("tp3_idle", 64'(idle), 64'(1));
    step();

    // Back-to-back last beats give two consecutive RACKs.
    slv_req.ar_valid = 1'b1;
    step();
    step();
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    step();
    step();
    mst_resp.r_valid = 1'b0;
    #1;
    check("tp4_rack_b", 64'(mst_req.rack), 64'(1));
    step();
    #1;
    check("tp4_idle", 64'(idle), 64'(1));
    step();

    // Randomized traffic on all channels.
    for (int c = 0; c < 400; c++) begin
      slv_req.ar_valid  = 1'($urandom_range(0, 1));
      slv_req.aw_valid  = 1'($urandom_range(0, 1));
      slv_req.w_valid   = 1'($urandom_range(0, 1));
      slv_req.r_ready   = 1'($urandom_range(0, 1));
      slv_req.b_ready   = 1'($urandom_range(0, 1));
      slv_req.rack      = 1'($urandom_range(0, 1));
      slv_req.wack      = 1'($urandom_range(0, 1));
      slv_req.ar.addr   = $urandom;
      slv_req.ar.id     = 4'($urandom);
      slv_req.aw.addr   = $urandom;
      slv_req.aw.len    = 8'($urandom);
      slv_req.w.data    = $urandom;
      mst_resp.ar_ready = 1'($urandom_range(0, 1));
      mst_resp.aw_ready = 1'($urandom_range(0, 1));
      mst_resp.w_ready  = 1'($urandom_range(0, 1));
      mst_resp.r.data   = $urandom;
      mst_resp.r.last   = 1'($urandom_range(0, 1));
      mst_resp.b.resp   = 2'($urandom);
      mst_resp.r_valid  = (rd_out > (rack_m ? 1 : 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
      mst_resp.b_valid  = (wr_out > (wack_m ? 1 : 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    drain();

    // B with nothing outstanding: sticky error, WACK still pulses, count stays zero.
    mst_resp.b_valid = 1'b1;
    step();
    mst_resp.b_valid = 1'b0;
    #1;
    check("tp5_wack", 64'(mst_req.wack), 64'(1));
    check("tp5_err", 64'(err), 64'(1));
    step();
    step();
    step();
    #1;
    check("tp5_err_sticky", 64'(err), 64'(1));
    check("tp5_idle", 64'(idle), 64'(1));

    // Asynchronous reset while full with RACK high.
    slv_req.ar_valid = 1'b1;
    step();
    step();
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    step();
    mst_resp.r_valid = 1'b0;
    slv_req.ar_valid = 1'b1;
    #1;
    check("tp6_rack_pre", 64'(mst_req.rack), 64'(1));
    check("tp6_full_pre", 64'(slv_resp.ar_ready), 64'(0));
    rst = 1'b1;
    #1;
    check("tp6_rack", 64'(mst_req.rack), 64'(0));
    check("tp6_wack", 64'(mst_req.wack), 64'(0));
    check("tp6_idle", 64'(idle), 64'(1));
    check("tp6_err", 64'(err), 64'(0));
    check("tp6_ready", 64'(slv_resp.ar_ready), 64'(1));
    slv_req.ar_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    slv_req.ar_valid = 1'b1;
    step();
    step();
    step();
    slv_req.ar_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
